// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults and the stereo sample type for the audio path
package audio_pkg;
   localparam int AUDIO_DATA_W = 16;
   localparam int AUDIO_SLOT_BITS = 32;
   localparam int AUDIO_BCLK_DIV = 4;
   localparam int AUDIO_FIFO_DEPTH = 4;
   localparam int FRAME_BITS = 2 * AUDIO_SLOT_BITS;
   typedef struct packed {
      logic [AUDIO_DATA_W-1:0] left;
      logic [AUDIO_DATA_W-1:0] right;
   } stereo_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous FIFO with wrapping pointers and a separate count
module audio_sample_fifo #(
   parameter int W = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   assign full = cnt == CW'(DEPTH);
   assign empty = cnt == '0;
   assign rdata = mem[rp];
   always_ff @(posedge clk)
      if (push) mem[wp] <= wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S master serializer for stereo PCM with a small sample FIFO.
// Optional underrun_cnt_o saturating counter under AUDIO_I2S_TX_UNDERRUN_CNT_EN.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int DATA_W = AUDIO_DATA_W,
   parameter int SLOT_BITS = AUDIO_SLOT_BITS,
   parameter int BCLK_DIV = AUDIO_BCLK_DIV,
   parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] left_i,
   input  logic [DATA_W-1:0] right_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              sample_req_o,
   output logic              underrun_o,
   output logic              bclk_o,
   output logic              lrclk_o,
   output logic              dacdat_o
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt_o
`endif
);
   localparam int FB = 2 * SLOT_BITS;
   localparam int BW = $clog2(FB);
   localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic [DATA_W-1:0] sh, sh_ld, right_q;
   logic [2*DATA_W-1:0] rdata, pair;
   logic run, wrap, tick, frame, half, push, pop, full, empty;

   // tick marks the clk cycle in which bclk_o falls; all serial outputs move then
   assign wrap = div_cnt == DW'(BCLK_DIV - 1);
   assign tick = wrap && bclk_o;
   assign bit_nxt = bit_cnt == BW'(FB - 1) ? '0 : bit_cnt + 1'b1;
   assign frame = tick && bit_nxt == '0;
   assign half = tick && bit_nxt == BW'(SLOT_BITS);
   assign ready_o = run && !full;
   assign push = valid_i && ready_o;
   assign pop = frame && !empty;
   assign pair = empty ? '0 : rdata;
   assign sh_ld = frame ? pair[2*DATA_W-1:DATA_W] : half ? right_q : sh;

   audio_sample_fifo #(.W(2 * DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk_i),
      .rst(rst_i),
      .push(push),
      .pop(pop),
      .wdata({left_i, right_i}),
      .rdata(rdata),
      .full(full),
      .empty(empty)
   );

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         run <= 1'b0;
         div_cnt <= '0;
         bclk_o <= 1'b0;
         bit_cnt <= BW'(FB - 1);
         lrclk_o <= 1'b0;
         dacdat_o <= 1'b0;
         sh <= '0;
         right_q <= '0;
         sample_req_o <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         run <= 1'b1;
         sample_req_o <= pop;
         underrun_o <= frame && empty;
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         if (wrap) bclk_o <= !bclk_o;
         if (tick) begin
            bit_cnt <= bit_nxt;
            lrclk_o <= (bit_nxt >= BW'(SLOT_BITS - 1)) && (bit_nxt != BW'(FB - 1));
            dacdat_o <= sh_ld[DATA_W-1];
            sh <= sh_ld << 1;
         end
         if (frame) right_q <= pair[DATA_W-1:0];
      end

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) underrun_cnt_o <= '0;
      else if (underrun_o && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 1'b1;
`endif
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench with an I2S receiver model decoding the serial stream
module tb_audio_i2s_tx;
   logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0;
   logic [15:0] left_i = '0, right_i = '0;
   logic ready_o, sample_req_o, underrun_o, bclk_o, lrclk_o, dacdat_o;
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] ucnt;
`endif
   int passed = 0, total = 0;

   audio_i2s_tx dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .left_i(left_i),
      .right_i(right_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .sample_req_o(sample_req_o),
      .underrun_o(underrun_o),
      .bclk_o(bclk_o),
      .lrclk_o(lrclk_o),
      .dacdat_o(dacdat_o)
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt_o(ucnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // receiver model: bit after the lrclk fall edge is the left MSB
   logic bp = 1'b0, lp = 1'b0, lrp = 1'b1, started = 1'b0;
   logic [15:0] lw = '0, rw = '0;
   int k = 0, und_n = 0, req_n = 0, ones_n = 0, lr_err = 0, zf_err = 0;
   time t_rise = 0, rise_per = 0, t_lr_rise = 0, t_lr_fall = 0, lr_per = 0, lr_high = 0;
   logic [31:0] rx[$];

   always @(negedge clk) begin
      if (rst_i) begin
         bp = 1'b0;
         lp = 1'b0;
         lrp = 1'b1;
         started = 1'b0;
         k = 0;
      end else begin
         if (underrun_o) und_n++;
         if (sample_req_o) req_n++;
         if (dacdat_o) ones_n++;
         if (lrclk_o && !lp) t_lr_rise = $time;
         if (!lrclk_o && lp) begin
            if (t_lr_fall != 0) lr_per = $time - t_lr_fall;
            t_lr_fall = $time;
            lr_high = $time - t_lr_rise;
         end
         lp = lrclk_o;
         if (bclk_o && !bp) begin
            if (t_rise != 0) rise_per = $time - t_rise;
            t_rise = $time;
            if (!lrclk_o && lrp) begin
               if (started) begin
                  if (dacdat_o) zf_err++;
                  rx.push_back({lw, rw});
               end
               started = 1'b1;
               k = 0;
            end else if (started) begin
               if (lrclk_o != (k >= 31)) lr_err++;
               if (k < 16) lw = {lw[14:0], dacdat_o};
               else if (k >= 32 && k < 48) rw = {rw[14:0], dacdat_o};
               else if (dacdat_o) zf_err++;
               k++;
            end
            lrp = lrclk_o;
         end
         bp = bclk_o;
      end
   end

   function automatic int nz();
      int c = 0;
      foreach (rx[i]) if (rx[i] != 0) c++;
      return c;
   endfunction

   task automatic wait_nz(input string tag, input int target, input int bound);
      int n = 0;
      while (nz() < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, nz(), target);
   endtask

   task automatic wait_underrun(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!underrun_o && n < 700);
      check(tag, underrun_o, 1);
   endtask

   initial begin
      int i, n, first_full, acc_bad, bad, s0, u0;
      logic [31:0] exp_q[$];
      repeat (3) @(negedge clk);
      check("rst_bclk", bclk_o, 0);
      check("rst_lrclk", lrclk_o, 0);
      check("rst_dacdat", dacdat_o, 0);
      check("rst_ready", ready_o, 0);
      check("rst_sreq", sample_req_o, 0);
      check("rst_underrun", underrun_o, 0);
      rst_i = 1'b0;
      repeat (1540) @(negedge clk);
      check("idle_ready", ready_o, 1);
      check("idle_underruns", und_n, 3);
      check("idle_sreq", req_n, 0);
      check("bclk_period", 32'(rise_per), 80);
      check("lrclk_period", 32'(lr_per), 5120);
      check("lrclk_high", 32'(lr_high), 2560);
      check("idle_dacdat_ones", ones_n, 0);

      rx.delete();
      s0 = req_n;
      left_i = 16'hA5C3;
      right_i = 16'h8001;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      wait_nz("t3_found", 1, 1300);
      bad = 32'hDEAD;
      foreach (rx[j]) if (rx[j] != 0) bad = rx[j];
      check("t3_pair", bad, 32'hA5C38001);
      check("t3_sreq_once", req_n - s0, 1);

      wait_underrun("t4_sync");
      rx.delete();
      i = 0;
      n = 0;
      first_full = -1;
      acc_bad = 0;
      while (i < 10 && n < 5000) begin
         @(negedge clk);
         n++;
         left_i = 16'h1000 + 16'(i);
         right_i = 16'h2000 + 16'(i);
         valid_i = 1'b1;
         if (ready_o) begin
            if (i >= 4 && !sample_req_o) acc_bad++;
            i++;
         end else if (first_full < 0) first_full = i;
      end
      @(negedge clk);
      valid_i = 1'b0;
      check("t4_accepted", i, 10);
      check("t4_full_after", first_full, 4);
      check("t4_one_per_frame", acc_bad, 0);
      wait_nz("t4_rx_count", 10, 3500);
      exp_q.delete();
      for (int j = 0; j < 10; j++) exp_q.push_back({16'h1000 + 16'(j), 16'h2000 + 16'(j)});
      bad = 0;
      n = 0;
      foreach (rx[j]) if (rx[j] != 0) begin
         if (n >= 10 || rx[j] != exp_q[n]) bad++;
         n++;
      end
      check("t4_order", bad, 0);

      wait_underrun("t5_sync");
      rx.delete();
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         left_i = 16'h3000 + 16'(j);
         right_i = 16'h4000 + 16'(j);
         valid_i = 1'b1;
      end
      @(negedge clk);
      valid_i = 1'b0;
      repeat (506) @(negedge clk);
      @(negedge clk);
      left_i = 16'h3004;
      right_i = 16'h4004;
      valid_i = 1'b1;
      check("t5_ready_at_pop3", ready_o, 1);
      @(negedge clk);
      check("t5_pop_pulse", sample_req_o, 1);
      check("t5_ready_cnt3", ready_o, 1);
      left_i = 16'h3005;
      right_i = 16'h4005;
      @(negedge clk);
      valid_i = 1'b0;
      check("t5_full_after", ready_o, 0);
      repeat (509) @(negedge clk);
      @(negedge clk);
      left_i = 16'h3006;
      right_i = 16'h4006;
      valid_i = 1'b1;
      check("t5_ready_at_pop4", ready_o, 0);
      @(negedge clk);
      valid_i = 1'b0;
      check("t5_pop2_pulse", sample_req_o, 1);
      wait_nz("t5_rx_count", 5, 3000);
      repeat (600) @(negedge clk);
      check("t5_no_extra", nz(), 5);
      bad = 0;
      n = 1;
      foreach (rx[j]) if (rx[j] != 0) begin
         if (rx[j] != {16'h3000 + 16'(n), 16'h4000 + 16'(n)}) bad++;
         n++;
      end
      check("t5_order", bad, 0);

      wait_underrun("t6_sync");
      @(negedge clk);
      left_i = 16'h7777;
      right_i = 16'h6666;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (300) @(negedge clk);
      check("t6_in_right", lrclk_o, 1);
      @(posedge clk);
      #2 rst_i = 1'b1;
      #1 check("t6_async_outs", {bclk_o, lrclk_o, dacdat_o, ready_o, sample_req_o, underrun_o}, 0);
      @(posedge clk);
      #2 rst_i = 1'b0;
      u0 = und_n;
      s0 = req_n;
      rx.delete();
      repeat (20) @(negedge clk);
      check("t6_underrun", und_n - u0, 1);
      check("t6_no_pop", req_n - s0, 0);
      n = 0;
      while (rx.size() == 0 && n < 700) begin
         @(negedge clk);
         n++;
      end
      check("t6_muted", rx.size() > 0 ? rx[0] : 32'hDEAD, 0);

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
      @(posedge clk);
      #2 rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      repeat (2100) @(negedge clk);
      check("ucnt_5", ucnt, 5);
      force dut.underrun_cnt_o = 16'hFFFE;
      @(negedge clk);
      release dut.underrun_cnt_o;
      repeat (1560) @(negedge clk);
      check("ucnt_sat", ucnt, 16'hFFFF);
`endif

      check("lr_phase_errors", lr_err, 0);
      check("zero_fill_errors", zf_err, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
